prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, the largest accepted word count.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the idle-byte limit while loading.
REQ-004 SHALL have clk  input  1  the single clock; all logic rises on its positive edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have start  input  1  single-cycle request to begin a load.
REQ-007 SHALL have in_valid  input  1  a byte is offered on in_data.
REQ-008 SHALL have in_data  input  8  offered byte.
REQ-009 SHALL have in_ready  output  1  loader accepts a byte; a transfer occurs on a cycle with in_valid=1 and in_ready=1.
REQ-010 SHALL have mem_w_en  output  1  instruction-memory write strobe.
REQ-011 SHALL have mem_w_addr  output  32  write byte address.
REQ-012 SHALL have mem_w_data  output  32  write data.
REQ-013 SHALL have cpu_rst_n  output  1  active-low hold of the core.
REQ-014 SHALL have busy  output  1  load in progress.
REQ-015 SHALL have done  output  1  last load completed successfully.
REQ-016 SHALL have err  output  3  error code of last load: 0 none, 1 bad magic, 2 bad length, 3 checksum, 4 timeout.

Function
REQ-017 SHALL implement states IDLE, MAGIC, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
REQ-018 SHALL move IDLE, DONE or ERROR to MAGIC on start=1, clearing done, err, word index, byte index, checksum and timeout counter; start in any other state SHALL be ignored.
REQ-019 SHALL drive in_ready=1 and busy=1 exactly in MAGIC, LEN0, LEN1, DATA, CSUM; otherwise both 0.
REQ-020 SHALL in MAGIC go to LEN0 on byte 8'hA5, else to ERROR with err=1.
REQ-021 SHALL take word count N little-endian: LEN0 byte = N[7:0], LEN1 byte = N[15:8].
REQ-022 SHALL on the LEN1 transfer go to ERROR with err=2 if N=0 or N>MAX_WORDS, else to DATA.
REQ-023 SHALL in DATA assemble each word from 4 bytes little-endian (first byte = bits 7:0).
REQ-024 SHALL, in the cycle after the 4th byte of word k transfers, pulse mem_w_en for exactly one cycle with mem_w_addr=ADDR_BASE+4*k and mem_w_data=assembled word.
REQ-025 SHALL hold mem_w_addr and mem_w_data stable when mem_w_en=0; mem_w_en SHALL never assert outside DATA/CSUM.
REQ-026 SHALL go from DATA to CSUM after the 4th byte of word N-1.
REQ-027 SHALL keep a running XOR of all 4*N payload bytes; the CSUM byte SHALL equal it for DONE, else ERROR with err=3.
REQ-028 SHALL count cycles without a transfer while busy; the counter resets on every transfer; on reaching TIMEOUT_CYCLES SHALL go to ERROR with err=4.
REQ-029 SHALL drive cpu_rst_n=0 from the cycle after start is accepted through MAGIC..CSUM and in ERROR; cpu_rst_n=1 in IDLE and DONE.
REQ-030 SHALL set done=1 in DONE, held until next accepted start.
REQ-031 SHALL leave words already written unchanged on any error (no rollback).
REQ-032 SHALL treat start=1 coincident with in_valid=1 in IDLE as start only; that byte is not consumed.

Reset
REQ-033 SHALL on rst_n=0, regardless of state, immediately enter IDLE with in_ready=0, busy=0, mem_w_en=0, mem_w_addr=ADDR_BASE, mem_w_data=0, cpu_rst_n=1, done=0, err=0.
REQ-034 SHALL abandon a load interrupted by reset without further writes.

Verification
REQ-035 start; bytes A5 02 00 13 00 00 00 6F 00 00 00 7C -> writes (0x0,0x00000013),(0x4,0x0000006F), one cycle each; done=1, err=0, cpu_rst_n rises.
REQ-036 start; byte 5A -> ERROR, err=1, in_ready=0, cpu_rst_n=0, no mem_w_en.
REQ-037 start; A5 00 00 -> err=2; separately A5 01 04 with MAX_WORDS=1024 (N=1025) -> err=2.
REQ-038 Scenario of REQ-035 with checksum byte 7D -> both words written, then err=3, done=0, cpu_rst_n=0.
REQ-039 TIMEOUT_CYCLES=16; start; A5 then no in_valid -> err=4 exactly 16 cycles after last transfer; in_valid toggling with gaps of 15 cycles -> no timeout.
REQ-040 rst_n low mid-DATA (after 2 bytes of word 0) -> outputs per REQ-033 asynchronously, no write; subsequent start restarts cleanly.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a framed image (magic, 16-bit word
// count, little-endian payload words, XOR checksum) and writes it word by word
// into instruction memory while holding the core in reset.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start                   single-cycle load request (IDLE/DONE/ERROR only)
//   in_valid, in_data       offered byte; in_ready accepts it
//   mem_w_en/addr/data      one-cycle instruction-memory write strobe
//   cpu_rst_n               active-low core hold
//   busy, done, err         load status (err: 0 ok,1 magic,2 length,3 csum,4 timeout)
module prog_loader #(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_w_en,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err
);

  localparam int unsigned    TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAGIC_BYTE = 8'hA5;
  localparam logic [2:0]     ERR_NONE   = 3'd0;
  localparam logic [2:0]     ERR_MAGIC  = 3'd1;
  localparam logic [2:0]     ERR_LEN    = 3'd2;
  localparam logic [2:0]     ERR_CSUM   = 3'd3;
  localparam logic [2:0]     ERR_TMO    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_MAGIC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic              loading;     // registered copy of "state in MAGIC..CSUM"
  logic [15:0]       word_idx;
  logic [15:0]       n_words;
  logic [1:0]        byte_idx;
  logic [7:0]        len_lo;
  logic [7:0]        csum;
  logic [23:0]       word_buf;
  logic [TO_W-1:0]   to_cnt;
  logic [15:0]       len_full;
  logic              len_bad;

  assign in_ready = loading;
  assign busy     = loading;

  // Word count as it stands on the LEN1 transfer.
  assign len_full = {in_data, len_lo};
  assign len_bad  = (len_full == 16'd0) || (32'(len_full) > 32'(MAX_WORDS));

  // Loader FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      loading    <= 1'b0;
      cpu_rst_n  <= 1'b1;
      done       <= 1'b0;
      err        <= ERR_NONE;
      mem_w_en   <= 1'b0;
      mem_w_addr <= ADDR_BASE;
      mem_w_data <= 32'd0;
      word_idx   <= 16'd0;
      n_words    <= 16'd0;
      byte_idx   <= 2'd0;
      len_lo     <= 8'd0;
      csum       <= 8'd0;
      word_buf   <= 24'd0;
      to_cnt     <= '0;
    end else begin
      mem_w_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state     <= S_MAGIC;
            loading   <= 1'b1;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_NONE;
            word_idx  <= 16'd0;
            byte_idx  <= 2'd0;
            csum      <= 8'd0;
            to_cnt    <= '0;
          end
        end
        default: begin
          if (in_valid) begin
            to_cnt <= '0;
            case (state)
              S_MAGIC: begin
                if (in_data == MAGIC_BYTE) begin
                  state <= S_LEN0;
                end else begin
                  state   <= S_ERROR;
                  loading <= 1'b0;
                  err     <= ERR_MAGIC;
                end
              end
              S_LEN0: begin
                len_lo <= in_data;
                state  <= S_LEN1;
              end
              S_LEN1: begin
                n_words <= len_full;
                if (len_bad) begin
                  state   <= S_ERROR;
                  loading <= 1'b0;
                  err     <= ERR_LEN;
                end else begin
                  state <= S_DATA;
                end
              end
              S_DATA: begin
                csum     <= csum ^ in_data;
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                  2'd0: word_buf[7:0]   <= in_data;
                  2'd1: word_buf[15:8]  <= in_data;
                  2'd2: word_buf[23:16] <= in_data;
                  default: begin
                    mem_w_en   <= 1'b1;
                    mem_w_addr <= ADDR_BASE + {14'd0, word_idx, 2'b00};
                    mem_w_data <= {in_data, word_buf};
                    word_idx   <= word_idx + 16'd1;
                    if (word_idx == n_words - 16'd1) state <= S_CSUM;
                  end
                endcase
              end
              S_CSUM: begin
                loading <= 1'b0;
                if (in_data == csum) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  cpu_rst_n <= 1'b1;
                end else begin
                  state <= S_ERROR;
                  err   <= ERR_CSUM;
                end
              end
              default: ;
            endcase
          end else if (to_cnt == TO_LAST) begin
            // Idle limit hit: abandon the load, words already written stay.
            state   <= S_ERROR;
            loading <= 1'b0;
            err     <= ERR_TMO;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued by the
// stimulus, a negedge monitor pops and compares on every mem_w_en; status
// outputs are compared against hand-computed values at fixed points.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_w_en;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic [2:0]  err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  prog_loader #(
    .ADDR_BASE(32'h0000_0000),
    .MAX_WORDS(1024),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_w_en(mem_w_en),
    .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data),
    .cpu_rst_n(cpu_rst_n),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (mem_w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 mem_w_addr, mem_w_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", mem_w_addr, e.addr);
        check("wr_data", mem_w_data, e.data);
      end
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      $display("FAIL send_ready_timeout: got in_ready=%0b expected 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] bs[]);
    foreach (bs[i]) send(bs[i]);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic [2:0] e,
                              input logic cr, input logic bz);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(cr));
    check({tag, "_busy"}, 32'(busy), 32'(bz));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(bz));
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic good_load(input string tag);
    logic [7:0] img[];
    img = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    expect_wr(32'h0, 32'h0000_0013);
    expect_wr(32'h4, 32'h0000_006F);
    do_start();
    check_status({tag, "_loading"}, 1'b0, 3'd0, 1'b0, 1'b1);
    send_seq(img);
    @(negedge clk);
    check_status({tag, "_end"}, 1'b1, 3'd0, 1'b1, 1'b0);
    check_drained(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[];
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    // reset values
    check_status("reset", 1'b0, 3'd0, 1'b1, 1'b0);
    check("reset_wen", 32'(mem_w_en), 32'd0);
    check("reset_waddr", mem_w_addr, 32'h0);
    check("reset_wdata", mem_w_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start with coincident in_valid in IDLE: byte must not be consumed
    in_valid = 1'b1;
    in_data  = 8'h5A;
    do_start();
    in_valid = 1'b0;
    check_status("start_coincident", 1'b0, 3'd0, 1'b0, 1'b1);
    good_load("good_after_coincident");
    check("hold_waddr", mem_w_addr, 32'h4);
    check("hold_wdata", mem_w_data, 32'h0000_006F);

    // bad magic
    do_start();
    send(8'h5A);
    check_status("bad_magic", 1'b0, 3'd1, 1'b0, 1'b0);

    // zero length
    do_start();
    s = '{8'hA5, 8'h00, 8'h00};
    send_seq(s);
    check_status("len_zero", 1'b0, 3'd2, 1'b0, 1'b0);

    // length 1025 > MAX_WORDS
    do_start();
    s = '{8'hA5, 8'h01, 8'h04};
    send_seq(s);
    check_status("len_1025", 1'b0, 3'd2, 1'b0, 1'b0);

    // checksum mismatch: both words still written
    expect_wr(32'h0, 32'h0000_0013);
    expect_wr(32'h4, 32'h0000_006F);
    do_start();
    s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D};
    send_seq(s);
    @(negedge clk);
    check_status("bad_csum", 1'b0, 3'd3, 1'b0, 1'b0);
    check_drained("bad_csum");

    // timeout exactly 16 idle cycles after the last transfer
    do_start();
    send(8'hA5);
    repeat (15) @(negedge clk);
    check_status("tmo_15", 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    check_status("tmo_16", 1'b0, 3'd4, 1'b0, 1'b0);

    // 15-cycle gaps never time out; word 0x44332211, csum 0x44
    expect_wr(32'h0, 32'h4433_2211);
    do_start();
    s = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    foreach (s[i]) begin
      repeat (15) @(negedge clk);
      send(s[i]);
    end
    @(negedge clk);
    check_status("gap15", 1'b1, 3'd0, 1'b1, 1'b0);
    check_drained("gap15");

    // reset in the middle of word 0
    do_start();
    s = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD};
    send_seq(s);
    #2;
    rst_n = 1'b0;
    #1;
    check_status("mid_reset", 1'b0, 3'd0, 1'b1, 1'b0);
    check("mid_reset_wen", 32'(mem_w_en), 32'd0);
    check("mid_reset_waddr", mem_w_addr, 32'h0);
    check("mid_reset_wdata", mem_w_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    good_load("restart");

    repeat (3) @(negedge clk);
    check_drained("final");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
